// File: rtl/pb_pkg.sv
// Shared PB size codes and lengths, used by the decoder and the PB length encoder.
// The test-length code is only recognised when PB_TEST_LEN_EN is defined.
package pb_pkg;

    localparam int CNT_W     = 12;
    localparam int NUM_CODES = 4;

    typedef logic [1:0]       pb_code_t;
    typedef logic [CNT_W-1:0] pb_len_t;

    localparam pb_len_t CNT_MAX = '1;

    localparam pb_code_t PB_16  = 2'd0;
    localparam pb_code_t PB_136 = 2'd1;
    localparam pb_code_t PB_520 = 2'd2;
    localparam pb_code_t PB_3   = 2'd3;

    localparam pb_len_t LEN_PB16  = 12'd64;
    localparam pb_len_t LEN_PB136 = 12'd544;
    localparam pb_len_t LEN_PB520 = 12'd2080;
    localparam pb_len_t LEN_PB3   = 12'd10;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } dec_state_t;

    typedef struct packed {
        pb_code_t code;
        pb_len_t  len;
        logic     err;
    } det_result_t;

    // Interleaver length L belonging to each size code.
    function automatic pb_len_t code_len(input pb_code_t code);
        pb_len_t len;
        case (code)
            PB_16:   len = LEN_PB16;
            PB_136:  len = LEN_PB136;
            PB_520:  len = LEN_PB520;
            default: len = LEN_PB3;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/pb_decoder_if.sv
// Beat input handshake and detection result bundle for pb_decoder.
// master = beat source / result consumer, slave = the decoder.
interface pb_decoder_if
    import pb_pkg::*;
    ();

    logic     in_valid;
    logic     in_first;
    logic     in_last;
    logic     in_ready;
    pb_code_t pb_size;
    pb_len_t  len_l;
    logic     det_valid;
    logic     det_err;

    modport master (
        output in_valid,
        output in_first,
        output in_last,
        input  in_ready,
        input  pb_size,
        input  len_l,
        input  det_valid,
        input  det_err
    );

    modport slave (
        input  in_valid,
        input  in_first,
        input  in_last,
        output in_ready,
        output pb_size,
        output len_l,
        output det_valid,
        output det_err
    );

endinterface

// File: rtl/pb_len_lut.sv
// Combinational beat-count to PB size code lookup.
// Config: PB_TEST_LEN_EN enables recognition of the 10-beat test PB (code 3).
module pb_len_lut
    import pb_pkg::*;
(
    input  pb_len_t  count,
    output pb_code_t code,
    output pb_len_t  len,
    output logic     match
);

    logic [NUM_CODES-1:0] code_en;
    logic [NUM_CODES-1:0] hit;

`ifdef PB_TEST_LEN_EN
    assign code_en = 4'b1111;
`else
    assign code_en = 4'b0111;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CODES; gi++) begin : g_hit
            assign hit[gi] = code_en[gi] && (count == code_len(pb_code_t'(gi)));
        end
    endgenerate

    // Lengths are distinct, so at most one hit bit is ever set.
    always_comb begin
        code  = PB_16;
        len   = count;
        match = 1'b0;
        for (int i = 0; i < NUM_CODES; i++) begin
            if (hit[i]) begin
                code  = pb_code_t'(i);
                len   = code_len(pb_code_t'(i));
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pb_decoder.sv
// PB size detector: counts accepted beats between first and last, classifies the
// length two cycles after the last beat. Optional test length via PB_TEST_LEN_EN.
module pb_decoder
    import pb_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    pb_decoder_if.slave  bus
);

    dec_state_t  state_reg, state_next;
    pb_len_t     cnt_reg, cnt_next;
    logic        ovf_reg, ovf_next;

    det_result_t res_reg, res_next;
    logic        res_valid_reg;
    det_result_t out_reg;
    logic        det_valid_reg;

    logic        ready;
    logic        beat;

    pb_code_t    lut_code;
    pb_len_t     lut_len;
    logic        lut_match;

    assign ready = (state_reg != DONE);
    assign beat  = bus.in_valid && ready;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (beat && bus.in_first) begin
                    cnt_next   = 12'd1;
                    ovf_next   = 1'b0;
                    state_next = bus.in_last ? DONE : COUNT;
                end
            end
            COUNT: begin
                if (beat) begin
                    if (bus.in_first) begin
                        // A new first beat abandons the PB in progress.
                        cnt_next   = 12'd1;
                        ovf_next   = 1'b0;
                        state_next = bus.in_last ? DONE : COUNT;
                    end else begin
                        if (cnt_reg == CNT_MAX) begin
                            ovf_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 12'd1;
                        end
                        if (bus.in_last) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    pb_len_lut u_lut (
        .count (cnt_reg),
        .code  (lut_code),
        .len   (lut_len),
        .match (lut_match)
    );

    always_comb begin
        res_next.code = lut_code;
        res_next.len  = lut_len;
        res_next.err  = 1'b0;
        if (!lut_match || ovf_reg) begin
            res_next.code = PB_16;
            res_next.len  = ovf_reg ? CNT_MAX : cnt_reg;
            res_next.err  = 1'b1;
        end
    end

    // Two stages after DONE: capture classification, then publish with det_valid.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            res_reg       <= '0;
            res_valid_reg <= 1'b0;
            out_reg       <= '0;
            det_valid_reg <= 1'b0;
        end else begin
            res_valid_reg <= (state_reg == DONE);
            if (state_reg == DONE) begin
                res_reg <= res_next;
            end
            det_valid_reg <= res_valid_reg;
            if (res_valid_reg) begin
                out_reg <= res_reg;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.pb_size   = out_reg.code;
    assign bus.len_l     = out_reg.len;
    assign bus.det_err   = out_reg.err;
    assign bus.det_valid = det_valid_reg;

endmodule

// File: tb/tb_pb_decoder.sv
// Directed self-checking bench for pb_decoder; inputs driven and outputs sampled on negedge.
module tb_pb_decoder;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   det_count = 0;
    int   rdy_low = 0;

    always #5 clk = ~clk;

    pb_decoder_if bus ();

    pb_decoder dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (n_rst && bus.det_valid) det_count++;
        if (n_rst && !bus.in_ready) rdy_low++;
    end

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Presents n beats; the final beat is left on the bus at the returning negedge.
    task automatic send_pb(input int n, input int max_gap, input bit with_first, input bit with_last);
        int miss = 0;
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) begin
                int g = $urandom_range(max_gap, 0);
                for (int k = 0; k < g; k++) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                    bus.in_first = 1'b1;
                    bus.in_last  = 1'b1;
                end
            end
            @(negedge clk);
            if (bus.in_ready !== 1'b1) miss++;
            bus.in_valid = 1'b1;
            bus.in_first = with_first && (i == 0);
            bus.in_last  = with_last && (i == n - 1);
        end
        checks++;
        if (miss != 0) begin
            errors++;
            $display("FAIL send_ready n=%0d: in_ready low on %0d beats, required 0", n, miss);
        end
    endtask

    task automatic check_det(input string name, input logic [1:0] exp_code,
                             input logic [11:0] exp_len, input logic exp_err);
        idle();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done_ready: got %b required 0", name, bus.in_ready);
        end
        checks++;
        if (bus.det_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid1: got %b required 0", name, bus.det_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.det_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s early_valid2: det_valid %b in_ready %b required 0 1", name, bus.det_valid, bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.det_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s det_valid: got %b required 1", name, bus.det_valid);
        end
        checks++;
        if (bus.pb_size !== exp_code || bus.len_l !== exp_len || bus.det_err !== exp_err) begin
            errors++;
            $display("FAIL %s result: size %0d len %h err %b, required size %0d len %h err %b",
                     name, bus.pb_size, bus.len_l, bus.det_err, exp_code, exp_len, exp_err);
        end
        @(negedge clk);
        checks++;
        if (bus.det_valid !== 1'b0 || bus.len_l !== exp_len || bus.pb_size !== exp_code) begin
            errors++;
            $display("FAIL %s pulse_hold: det_valid %b len %h size %0d, required 0 %h %0d",
                     name, bus.det_valid, bus.len_l, bus.pb_size, exp_len, exp_code);
        end
        $display("PB %s: size %0d len %h err %b", name, bus.pb_size, bus.len_l, bus.det_err);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (bus.det_valid !== 1'b0 || bus.pb_size !== 2'd0 || bus.len_l !== 12'h000 || bus.det_err !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: det_valid %b size %0d len %h err %b, required all 0",
                     name, bus.det_valid, bus.pb_size, bus.len_l, bus.det_err);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", bus.in_ready);
        end
        check_outputs_zero("after_reset");
    endtask

    task automatic test_pb16();
        send_pb(64, 0, 1'b1, 1'b1);
        check_det("pb16", 2'd0, 12'h040, 1'b0);
    endtask

    task automatic test_pb136_gaps();
        send_pb(544, 2, 1'b1, 1'b1);
        check_det("pb136_gaps", 2'd1, 12'h220, 1'b0);
    endtask

    task automatic test_pb520();
        send_pb(2080, 0, 1'b1, 1'b1);
        check_det("pb520", 2'd2, 12'h820, 1'b0);
    endtask

    task automatic test_mismatch();
        send_pb(100, 0, 1'b1, 1'b1);
        check_det("len100", 2'd0, 12'h064, 1'b1);
    endtask

    task automatic test_overflow();
        send_pb(4200, 0, 1'b1, 1'b1);
        check_det("len4200", 2'd0, 12'hFFF, 1'b1);
    endtask

    task automatic test_single_beat();
        send_pb(1, 0, 1'b1, 1'b1);
        check_det("single", 2'd0, 12'h001, 1'b1);
    endtask

    task automatic test_len10();
        send_pb(10, 1, 1'b1, 1'b1);
`ifdef PB_TEST_LEN_EN
        check_det("len10", 2'd3, 12'h00A, 1'b0);
`else
        check_det("len10", 2'd0, 12'h00A, 1'b1);
`endif
    endtask

    task automatic test_restart();
        int det0 = det_count;
        int rdy0 = rdy_low;
        send_pb(30, 0, 1'b1, 1'b0);
        send_pb(64, 0, 1'b1, 1'b1);
        check_det("restart", 2'd0, 12'h040, 1'b0);
        repeat (3) idle();
        checks++;
        if (det_count - det0 != 1) begin
            errors++;
            $display("FAIL restart_pulses: got %0d required 1", det_count - det0);
        end
        checks++;
        if (rdy_low - rdy0 != 1) begin
            errors++;
            $display("FAIL restart_ready_low: got %0d cycles required 1", rdy_low - rdy0);
        end
    endtask

    task automatic test_reset_mid();
        int det0;
        send_pb(300, 0, 1'b1, 1'b0);
        @(negedge clk);
        n_rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready: got %b required 1", bus.in_ready);
        end
        @(negedge clk);
        n_rst = 1'b1;
        det0 = det_count;
        send_pb(20, 0, 1'b0, 1'b1);
        repeat (6) idle();
        checks++;
        if (det_count != det0) begin
            errors++;
            $display("FAIL stray_beats: got %0d pulses required 0", det_count - det0);
        end
        check_outputs_zero("stray_beats");
        send_pb(64, 0, 1'b1, 1'b1);
        check_det("post_reset", 2'd0, 12'h040, 1'b0);
        repeat (2) idle();
        checks++;
        if (det_count - det0 != 1) begin
            errors++;
            $display("FAIL post_reset_pulses: got %0d required 1", det_count - det0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        test_reset();
        test_pb16();
        test_pb136_gaps();
        test_pb520();
        test_mismatch();
        test_overflow();
        test_single_beat();
        test_len10();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
